lcd1602_driver: RTL



---
 rtl/lcd_pkg.sv | 59 +++++
 rtl/lcd_byte_writer.sv | 82 ++++++++
 rtl/lcd1602_driver.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/lcd_pkg.sv
// lcd_pkg: shared state encodings, HD44780 command bytes and small helpers
// used by lcd1602_driver and lcd_byte_writer.
// Optional feature macro: LCD_CHANGE_ONLY_EN (adds the IDLE top-level state).
package lcd_pkg;

    // Top-level frame sequencer states
    typedef enum logic [3:0] {
        ST_POWER_WAIT,
        ST_INIT,
        ST_SNAPSHOT,
        ST_ADDR0,
        ST_ROW0,
        ST_ADDR1,
        ST_ROW1,
        ST_FRAME_END
`ifdef LCD_CHANGE_ONLY_EN
        , ST_IDLE
`endif
    } lcd_state_t;

    // Single-byte bus transaction phases
    typedef enum logic [1:0] {
        WR_IDLE,
        WR_SETUP,
        WR_PULSE,
        WR_HOLD
    } wr_state_t;

    localparam logic [7:0] LCD_FUNC_SET = 8'h38;
    localparam logic [7:0] LCD_DISP_ON  = 8'h0C;
    localparam logic [7:0] LCD_ENTRY    = 8'h06;
    localparam logic [7:0] LCD_CLEAR    = 8'h01;
    localparam logic [7:0] LCD_ROW0     = 8'h80;
    localparam logic [7:0] LCD_ROW1     = 8'hC0;
    localparam logic [7:0] ASCII_SPACE  = 8'h20;

    // Width of a counter able to hold the larger of two microsecond delays
    function automatic int delay_width(input int a, input int b);
        return $clog2(((a > b) ? a : b) + 1);
    endfunction

    // Anything the panel cannot show as plain ASCII is replaced with a space
    function automatic logic [7:0] lcd_printable(input logic [7:0] ch);
        return ((ch < 8'h20) || (ch > 8'h7E)) ? ASCII_SPACE : ch;
    endfunction

    // Power-up command list, issued in index order 0..3
    function automatic logic [7:0] init_cmd(input logic [1:0] idx);
        logic [7:0] cmd;
        case (idx)
            2'd0:    cmd = LCD_FUNC_SET;
            2'd1:    cmd = LCD_DISP_ON;
            2'd2:    cmd = LCD_ENTRY;
            default: cmd = LCD_CLEAR;
        endcase
        return cmd;
    endfunction

endpackage

// File: rtl/lcd_byte_writer.sv
// lcd_byte_writer: drives one byte onto the HD44780 bus as SETUP (1 us),
// PULSE (enable high, 1 us) and HOLD (execution wait). rs/data are latched
// at start and held through all three phases so enable never rises while
// the bus is changing. done pulses in the cycle the final HOLD tick lands.
module lcd_byte_writer
    import lcd_pkg::*;
#(
    parameter int CMD_US   = 50,
    parameter int CLEAR_US = 2000,
    parameter int DLY_W    = 11
) (
    input  logic       clk,
    input  logic       nRst,
    input  logic       start,
    input  logic       rs,
    input  logic [7:0] data,
    input  logic       us_tick,
    output logic       busy,
    output logic       done,
    output logic       lcd_rs,
    output logic [7:0] lcd_data,
    output logic       lcd_en
);

    wr_state_t        state;
    wr_state_t        state_next;
    logic [DLY_W-1:0] hold_cnt;
    logic [DLY_W-1:0] hold_len_m1;
    logic             hold_last;

    assign hold_len_m1 = (!lcd_rs && (lcd_data == LCD_CLEAR)) ? DLY_W'(CLEAR_US - 1)
                                                               : DLY_W'(CMD_US - 1);
    assign hold_last   = (hold_cnt == hold_len_m1);

    // Phase register
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state <= WR_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Phase advance: every phase boundary lands on a microsecond tick
    always_comb begin
        state_next = state;
        case (state)
            WR_IDLE:  if (start)                state_next = WR_SETUP;
            WR_SETUP: if (us_tick)              state_next = WR_PULSE;
            WR_PULSE: if (us_tick)              state_next = WR_HOLD;
            WR_HOLD:  if (us_tick && hold_last) state_next = WR_IDLE;
            default:                            state_next = WR_IDLE;
        endcase
    end

    // Bus value latch and execution-wait counter
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            lcd_rs   <= 1'b0;
            lcd_data <= 8'h00;
            hold_cnt <= '0;
        end else begin
            if ((state == WR_IDLE) && start) begin
                lcd_rs   <= rs;
                lcd_data <= data;
            end
            if (state != WR_HOLD) begin
                hold_cnt <= '0;
            end else if (us_tick) begin
                hold_cnt <= hold_cnt + DLY_W'(1);
            end
        end
    end

    // Handshake and strobe decode
    always_comb begin
        busy   = (state != WR_IDLE);
        lcd_en = (state == WR_PULSE);
        done   = (state == WR_HOLD) && us_tick && hold_last;
    end

endmodule

// File: rtl/lcd1602_driver.sv
// lcd1602_driver: runs the HD44780 power-up sequence, then repeatedly
// snapshots the two 16-character row buffers and writes them to a 16x2 LCD
// over the 8-bit parallel bus.
// Optional feature macro: LCD_CHANGE_ONLY_EN -- when defined, the driver
// parks in IDLE after each frame and only rewrites when an input row differs
// from the last snapshot.
module lcd1602_driver
    import lcd_pkg::*;
#(
    parameter int CLK_PER_US  = 12,
    parameter int POWER_UP_US = 40000,
    parameter int CMD_US      = 50,
    parameter int CLEAR_US    = 2000
) (
    input  logic         clk,
    input  logic         nRst,
    input  logic [127:0] top,
    input  logic [127:0] bottom,
    output logic [7:0]   lcd_data,
    output logic         lcd_rs,
    output logic         lcd_rw,
    output logic         lcd_en,
    output logic         ready,
    output logic         frame_done
);

    localparam int DLY_W = delay_width(POWER_UP_US, CLEAR_US);
    localparam int PRE_W = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;

    lcd_state_t       state;
    lcd_state_t       state_next;
    logic [PRE_W-1:0] pre_cnt;
    logic             us_tick;
    logic [DLY_W-1:0] pwr_cnt;
    logic [1:0]       init_idx;
    logic [3:0]       col;
    logic [127:0]     snap_top;
    logic [127:0]     snap_bot;
    logic             ready_q;
    logic             wr_start;
    logic             wr_rs;
    logic [7:0]       wr_data;
    logic             wr_busy;
    logic             wr_done;

    assign us_tick = (pre_cnt == PRE_W'(CLK_PER_US - 1));
    assign lcd_rw  = 1'b0;
    assign ready   = ready_q;

    // Free-running microsecond prescaler
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            pre_cnt <= '0;
        end else if (us_tick) begin
            pre_cnt <= '0;
        end else begin
            pre_cnt <= pre_cnt + PRE_W'(1);
        end
    end

    // Frame sequencer state register
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state <= ST_POWER_WAIT;
        end else begin
            state <= state_next;
        end
    end

    // Frame sequencer transitions; byte states advance on the writer's done
    always_comb begin
        state_next = state;
        case (state)
            ST_POWER_WAIT: if (us_tick && (pwr_cnt == DLY_W'(POWER_UP_US - 1)))
                               state_next = ST_INIT;
            ST_INIT:       if (wr_done && (init_idx == 2'd3)) state_next = ST_SNAPSHOT;
            ST_SNAPSHOT:   state_next = ST_ADDR0;
            ST_ADDR0:      if (wr_done) state_next = ST_ROW0;
            ST_ROW0:       if (wr_done && (col == 4'd15)) state_next = ST_ADDR1;
            ST_ADDR1:      if (wr_done) state_next = ST_ROW1;
            ST_ROW1:       if (wr_done && (col == 4'd15)) state_next = ST_FRAME_END;
`ifdef LCD_CHANGE_ONLY_EN
            ST_FRAME_END:  state_next = ST_IDLE;
            ST_IDLE:       if ((top != snap_top) || (bottom != snap_bot))
                               state_next = ST_SNAPSHOT;
`else
            ST_FRAME_END:  state_next = ST_SNAPSHOT;
`endif
            default:       state_next = ST_POWER_WAIT;
        endcase
    end

    // Delay, index and column counters, row snapshot and sticky ready flag
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            pwr_cnt  <= '0;
            init_idx <= 2'd0;
            col      <= 4'd0;
            snap_top <= '0;
            snap_bot <= '0;
            ready_q  <= 1'b0;
        end else begin
            if ((state == ST_POWER_WAIT) && us_tick) begin
                pwr_cnt <= pwr_cnt + DLY_W'(1);
            end
            if ((state == ST_INIT) && wr_done) begin
                init_idx <= init_idx + 2'd1;
            end
            if (((state == ST_ROW0) || (state == ST_ROW1)) && wr_done) begin
                col <= col + 4'd1;
            end
            if (state == ST_SNAPSHOT) begin
                snap_top <= top;
                snap_bot <= bottom;
            end
            if (state_next == ST_SNAPSHOT) begin
                ready_q <= 1'b1;
            end
        end
    end

    // Byte selection for the writer and frame completion strobe
    always_comb begin
        wr_start   = 1'b0;
        wr_rs      = 1'b0;
        wr_data    = 8'h00;
        frame_done = (state == ST_FRAME_END);
        case (state)
            ST_INIT: begin
                wr_data  = init_cmd(init_idx);
                wr_start = !wr_busy;
            end
            ST_ADDR0: begin
                wr_data  = LCD_ROW0;
                wr_start = !wr_busy;
            end
            ST_ROW0: begin
                wr_rs    = 1'b1;
                wr_data  = lcd_printable(snap_top[{~col, 3'b000} +: 8]);
                wr_start = !wr_busy;
            end
            ST_ADDR1: begin
                wr_data  = LCD_ROW1;
                wr_start = !wr_busy;
            end
            ST_ROW1: begin
                wr_rs    = 1'b1;
                wr_data  = lcd_printable(snap_bot[{~col, 3'b000} +: 8]);
                wr_start = !wr_busy;
            end
            default: begin
                wr_start = 1'b0;
            end
        endcase
    end

    lcd_byte_writer #(
        .CMD_US   (CMD_US),
        .CLEAR_US (CLEAR_US),
        .DLY_W    (DLY_W)
    ) u_writer (
        .clk      (clk),
        .nRst     (nRst),
        .start    (wr_start),
        .rs       (wr_rs),
        .data     (wr_data),
        .us_tick  (us_tick),
        .busy     (wr_busy),
        .done     (wr_done),
        .lcd_rs   (lcd_rs),
        .lcd_data (lcd_data),
        .lcd_en   (lcd_en)
    );

endmodule
